// File: rtl/alu_result_stage.sv
// Output-side ALU result stage: a two-entry skid buffer with valid/ready on both sides and a delivered-result counter.
// Optional sticky {C, V} status accumulation is enabled by defining ALU_OUT_STICKY_EN.
module alu_result_stage #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_result,
  input  logic [2:0]   in_op,
  input  logic [3:0]   in_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [2:0]   out_op,
  output logic [3:0]   out_flags,
  output logic [7:0]   result_count,
  input  logic         clr_sticky,
  output logic [1:0]   sticky_cv
);

  localparam int EW = N + 7;

  logic [EW-1:0] in_entry;
  logic [EW-1:0] head_reg;
  logic [EW-1:0] head_next;
  logic [EW-1:0] tail_reg;
  logic [EW-1:0] tail_next;
  logic [1:0]    occ_reg;
  logic [1:0]    occ_next;
  logic [7:0]    count_reg;
  logic          push;
  logic          pop;

  assign in_entry = {in_result, in_op, in_flags};

  // in_ready depends only on registered occupancy, so out_ready never reaches it combinationally.
  assign in_ready  = (occ_reg != 2'd2);
  assign out_valid = (occ_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result   = head_reg[EW-1:7];
  assign out_op       = head_reg[6:4];
  assign out_flags    = head_reg[3:0];
  assign result_count = count_reg;

  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    occ_next  = occ_reg;
    case (occ_reg)
      2'd0: begin
        if (push) begin
          head_next = in_entry;
          occ_next  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_next = in_entry;
        end else if (push) begin
          tail_next = in_entry;
          occ_next  = 2'd2;
        end else if (pop) begin
          occ_next  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_next = tail_reg;
          occ_next  = 2'd1;
        end
      end
      default: begin
        occ_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      occ_reg   <= 2'd0;
      count_reg <= 8'd0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      occ_reg   <= occ_next;
      if (pop) begin
        count_reg <= count_reg + 8'd1;
      end
    end
  end

`ifdef ALU_OUT_STICKY_EN
  logic [1:0] sticky_reg;
  logic [1:0] sticky_next;

  // Per bit: a popped C/V flag sets the bit even when a clear arrives in the same cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sticky
      always_comb begin
        sticky_next[gi] = clr_sticky ? 1'b0 : sticky_reg[gi];
        if (pop && head_reg[gi]) begin
          sticky_next[gi] = 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_reg <= 2'b00;
    end else begin
      sticky_reg <= sticky_next;
    end
  end

  assign sticky_cv = sticky_reg;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_cv         = 2'b00;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (N = 4): handshake, ordering, streaming, counter wrap, sticky status, reset.
module tb_alu_result_stage;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_result;
  logic [2:0]   in_op;
  logic [3:0]   in_flags;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [2:0]   out_op;
  logic [3:0]   out_flags;
  logic [7:0]   result_count;
  logic         clr_sticky;
  logic [1:0]   sticky_cv;

  int checks_cnt;
  int fail_cnt;

  alu_result_stage #(.N(N)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_result(in_result),
    .in_op(in_op),
    .in_flags(in_flags),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_op(out_op),
    .out_flags(out_flags),
    .result_count(result_count),
    .clr_sticky(clr_sticky),
    .sticky_cv(sticky_cv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=%0h", tag, got);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] r, input logic [2:0] o, input logic [3:0] f);
    in_valid  = v;
    in_result = r;
    in_op     = o;
    in_flags  = f;
  endtask

  logic [1:0] exp_sticky_c;
  logic [1:0] exp_sticky_v;

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
`ifdef ALU_OUT_STICKY_EN
    exp_sticky_c = 2'b10;
    exp_sticky_v = 2'b01;
`else
    exp_sticky_c = 2'b00;
    exp_sticky_v = 2'b00;
`endif
    reset      = 1'b1;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b1, 4'h7, 3'd5, 4'hF);
    step();
    step();
    reset = 1'b0;
    drive(1'b0, 4'h0, 3'd0, 4'h0);

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_count", 32'(result_count), 32'd0);
    check("rst_sticky", 32'(sticky_cv), 32'd0);

    // Single push then pop
    out_ready = 1'b1;
    drive(1'b1, 4'hA, 3'd2, 4'b1000);
    step();
    drive(1'b0, 4'h0, 3'd0, 4'h0);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_result", 32'(out_result), 32'hA);
    check("single_op", 32'(out_op), 32'd2);
    check("single_flags", 32'(out_flags), 32'b1000);
    step();
    check("single_after_valid", 32'(out_valid), 32'd0);
    check("single_count", 32'(result_count), 32'd1);
    check("single_hold_result", 32'(out_result), 32'hA);

    // Back-pressure: fill both entries, third held upstream
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 3'd1, 4'h0);
    step();
    check("bp_ready_occ1", 32'(in_ready), 32'd1);
    drive(1'b1, 4'h2, 3'd1, 4'h0);
    step();
    check("bp_ready_occ2", 32'(in_ready), 32'd0);
    check("bp_head1", 32'(out_result), 32'h1);
    drive(1'b1, 4'h3, 3'd1, 4'h0);
    step();
    check("bp_ready_hold", 32'(in_ready), 32'd0);
    check("bp_head1_hold", 32'(out_result), 32'h1);
    out_ready = 1'b1;
    step();
    check("bp_head2", 32'(out_result), 32'h2);
    check("bp_ready_rise", 32'(in_ready), 32'd1);
    check("bp_count2", 32'(result_count), 32'd2);
    step();
    drive(1'b0, 4'h0, 3'd0, 4'h0);
    check("bp_head3", 32'(out_result), 32'h3);
    check("bp_valid3", 32'(out_valid), 32'd1);
    step();
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_count4", 32'(result_count), 32'd4);

    // Streaming: one result per cycle for 20 results
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'((i + 5) % 16), 3'(i % 8), 4'h0);
      step();
      check($sformatf("stream_result_%0d", i), 32'(out_result), 32'((i + 5) % 16));
      check($sformatf("stream_ready_%0d", i), 32'(in_ready), 32'd1);
    end
    drive(1'b0, 4'h0, 3'd0, 4'h0);
    step();
    check("stream_empty", 32'(out_valid), 32'd0);
    check("stream_count", 32'(result_count), 32'd24);

    // Sticky status: C then clear with simultaneous V
    drive(1'b1, 4'h4, 3'd3, 4'b0010);
    step();
    drive(1'b0, 4'h0, 3'd0, 4'h0);
    step();
    check("sticky_c", 32'(sticky_cv), 32'(exp_sticky_c));
    drive(1'b1, 4'h5, 3'd3, 4'b0001);
    step();
    drive(1'b0, 4'h0, 3'd0, 4'h0);
    clr_sticky = 1'b1;
    step();
    check("sticky_clr_set_v", 32'(sticky_cv), 32'(exp_sticky_v));
    step();
    clr_sticky = 1'b0;
    check("sticky_clr_only", 32'(sticky_cv), 32'd0);
    check("sticky_count", 32'(result_count), 32'd26);

    // Counter wrap: 230 more pops takes 26 to 256 = 0
    for (int k = 1; k <= 230; k++) begin
      drive(1'b1, 4'(k % 16), 3'd0, 4'h0);
      step();
    end
    check("wrap_count_255", 32'(result_count), 32'd255);
    drive(1'b0, 4'h0, 3'd0, 4'h0);
    step();
    check("wrap_count_0", 32'(result_count), 32'd0);

    // Reset with occupancy 2
    out_ready = 1'b0;
    drive(1'b1, 4'h5, 3'd6, 4'b0011);
    step();
    drive(1'b1, 4'h6, 3'd7, 4'b0011);
    step();
    check("pre_rst_ready", 32'(in_ready), 32'd0);
    check("pre_rst_count", 32'(result_count), 32'd0);
    reset      = 1'b1;
    out_ready  = 1'b1;
    clr_sticky = 1'b1;
    step();
    reset      = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b0, 4'h0, 3'd0, 4'h0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_result", 32'(out_result), 32'd0);
    check("mid_rst_op", 32'(out_op), 32'd0);
    check("mid_rst_flags", 32'(out_flags), 32'd0);
    check("mid_rst_count", 32'(result_count), 32'd0);
    check("mid_rst_sticky", 32'(sticky_cv), 32'd0);
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Output-side pipeline stage of the Lab 2 ALU datapath: the counterpart of the operand-capture register at the ALU input. Accepts the combinational ALU result, opcode and status flags through a valid/ready handshake, buffers up to two results in a skid buffer, and presents them in order to the display/consumer side. Also counts delivered results and, optionally, accumulates sticky carry/overflow status.

## Interface
Parameters:
- N, 4, result width in bits (N ≥ 2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream result valid this cycle
- in_ready  out  1  stage can accept a result this cycle
- in_result  in  N  ALU result
- in_op  in  3  opcode that produced the result
- in_flags  in  4  {N, Z, C, V} from ALU
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head entry
- out_result  out  N  head result
- out_op  out  3  head opcode
- out_flags  out  4  head {N, Z, C, V}
- result_count  out  8  number of results delivered since reset
- clr_sticky  in  1  clear sticky status
- sticky_cv  out  2  {C, V} sticky status

## Operation
- Push = in_valid && in_ready; pop = out_valid && out_ready.
- Storage: two entries (head, tail) of {result, op, flags}; occupancy register 0..2.
- in_ready = (occupancy < 2), derived from registered occupancy only; no combinational path from out_ready to in_ready.
- out_valid = (occupancy ≠ 0); out_result/out_op/out_flags always drive the head entry.
- Occupancy transitions:
  - 0: push → 1 (entry written to head).
  - 1: push only → 2 (tail); pop only → 0; push+pop → 1, new entry becomes head.
  - 2: pop → 1, tail moves to head; push impossible (in_ready = 0).
- Order strictly FIFO; no entry dropped or duplicated.
- When occupancy returns to 0, head contents hold their last value (out_valid = 0 marks them invalid).
- Data inputs ignored when push is not asserted.
- result_count increments by 1 on each pop; wraps 255 → 0.
- Upstream must hold in_* stable while in_valid && !in_ready; consumer may drop out_ready at any time.

## Timing
- Reset (synchronous, on rising edge with reset = 1): occupancy = 0, head/tail = 0, out_valid = 0, in_ready = 1 after the edge, out_result = 0, out_op = 0, out_flags = 0, result_count = 0, sticky_cv = 0.
- Reset mid-operation discards all buffered entries; asserted reset overrides push, pop and clr_sticky in that cycle.
- Latency: push at edge k → out_valid = 1 and data visible from edge k (visible in cycle k+1) when occupancy was 0.
- Throughput: one result per cycle sustained while out_ready = 1.
- in_ready falls the cycle after occupancy reaches 2; rises the cycle after a pop from 2.

## Configuration
- ALU_OUT_STICKY_EN defined: on each pop, sticky_cv |= {out_flags[1], out_flags[0]}; clr_sticky = 1 clears sticky_cv on next edge; if clr_sticky and a pop with C or V set occur in the same cycle, the new bits are set (set wins).
- Not defined: sticky_cv constant 2'b00; clr_sticky ignored; no sticky registers.

## Test plan
- Reset then single push {result=4'hA, op=3'd2, flags=4'b1000} with out_ready=1 → out_valid=1 next cycle with same values, popped, result_count=1, out_valid=0 after.
- out_ready=0, push 3 results (1,2,3) back to back → in_ready=0 after second push, third held upstream; release out_ready → outputs 1,2,3 in order, result_count=3.
- Continuous push+pop with occupancy 1 for 20 cycles → one result per cycle, in_ready stays 1, result_count=20.
- 256 pops → result_count wraps to 0.
- With ALU_OUT_STICKY_EN: pop flags C=1 → sticky_cv=2'b10; clr_sticky with simultaneous pop V=1 → sticky_cv=2'b01; without macro sticky_cv stays 0.
- Reset asserted with occupancy 2 → next cycle out_valid=0, in_ready=1, all outputs 0.
